// File: rtl/serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_ctrl
// Description : Bit-serial unsigned subtractor. A single 1-bit subtractor
//               cell is reused once per clock, LSB first, to form a - b
//               modulo 2^WIDTH together with the final borrow.
// Ports       :
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   request a subtraction (accepted only while idle)
//   a, b       in   minuend / subtrahend, captured when start is accepted
//   busy       out  high while bits are being processed
//   done       out  one-cycle pulse when diff/borrow_out are updated
//   diff       out  registered result a - b (mod 2^WIDTH)
//   borrow_out out  registered final borrow (1 iff a < b, unsigned)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // Counter only has to reach WIDTH-1; a single bit is enough for WIDTH=2.
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             borrow;
  logic [CW-1:0]    count;

  // Shared subtractor cell operating on the current operand LSBs.
  logic x_bit;
  logic y_bit;
  logic d_bit;
  logic bout_bit;
  logic last_bit;

  assign x_bit    = a_sh[0];
  assign y_bit    = b_sh[0];
  assign d_bit    = x_bit ^ y_bit ^ borrow;
  assign bout_bit = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow);
  assign last_bit = (count == LAST_BIT);

  // Status flags come straight from the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:                  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand/result shift registers, borrow flop, bit counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      borrow     <= 1'b0;
      count      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= 1'b0;
            count  <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          // Each new difference bit enters at the MSB so that after WIDTH
          // shifts bit 0 has travelled down to position 0.
          res_sh <= {d_bit, res_sh[WIDTH-1:1]};
          borrow <= bout_bit;
          count  <= count + CW'(1);
          if (last_bit) begin
            diff       <= {d_bit, res_sh[WIDTH-1:1]};
            borrow_out <= bout_bit;
          end
        end
        default: begin
          // DONE: outputs and internal state simply hold.
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor_ctrl
// Description : Self-checking bench for serial_subtractor_ctrl. Exercises an
//               8-bit instance (vectors, random, corner sequences) and a
//               4-bit instance (full operand sweep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8;
  logic [7:0] a8, b8, diff8;
  logic       busy8, done8, bo8;

  logic       start4;
  logic [3:0] a4, b4, diff4;
  logic       busy4, done4, bo4;

  int total = 0;
  int bad   = 0;
  int dcnt8 = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );

  // Count done pulses of the 8-bit instance, sampled mid-cycle.
  always @(negedge clk) if (done8) dcnt8 <= dcnt8 + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_diff;
    logic       exp_bo;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: plain unsigned arithmetic.
  function automatic logic [31:0] ref_diff(input int w, input int x, input int y);
    return 32'((x - y) & ((1 << w) - 1));
  endfunction

  // Drives one operation on the selected instance and checks latency,
  // busy duration, result and the single-cycle done pulse. Called at a
  // negedge; returns at a negedge with the instance back in IDLE.
  task automatic run_op(input int w, input int x, input int y, input string nm,
                        input logic [7:0] exp_d, input logic exp_b);
    int cyc = 0;
    int bcnt = 0;
    logic dn, bz;
    if (w == 8) begin start8 = 1'b1; a8 = 8'(x); b8 = 8'(y); end
    else        begin start4 = 1'b1; a4 = 4'(x); b4 = 4'(y); end
    @(negedge clk);
    // Operands change right after acceptance; result must be unaffected.
    if (w == 8) begin start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); end
    else        begin start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); end
    dn = (w == 8) ? done8 : done4;
    bz = (w == 8) ? busy8 : busy4;
    while (!dn && cyc < 40) begin
      if (bz) bcnt++;
      @(negedge clk);
      cyc++;
      dn = (w == 8) ? done8 : done4;
      bz = (w == 8) ? busy8 : busy4;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(w));
    chk({nm, " busy_cycles"}, 32'(bcnt), 32'(w));
    chk({nm, " busy_with_done"}, {31'd0, bz}, 32'd0);
    if (w == 8) begin
      chk({nm, " diff"}, {24'd0, diff8}, {24'd0, exp_d});
      chk({nm, " borrow"}, {31'd0, bo8}, {31'd0, exp_b});
    end else begin
      chk({nm, " diff"}, {28'd0, diff4}, {28'd0, exp_d[3:0]});
      chk({nm, " borrow"}, {31'd0, bo4}, {31'd0, exp_b});
    end
    @(negedge clk);
    dn = (w == 8) ? done8 : done4;
    chk({nm, " done_single"}, {31'd0, dn}, 32'd0);
  endtask

  initial begin
    int x, y, d0;
    logic [7:0] hold;
    vecs[0] = '{8'd5,   8'd3,   8'h02, 1'b0};
    vecs[1] = '{8'd3,   8'd5,   8'hFE, 1'b1};
    vecs[2] = '{8'd0,   8'd1,   8'hFF, 1'b1};
    vecs[3] = '{8'hFF,  8'hFF,  8'h00, 1'b0};
    vecs[4] = '{8'd0,   8'd0,   8'h00, 1'b0};
    vecs[5] = '{8'hFF,  8'h00,  8'hFF, 1'b0};
    vecs[6] = '{8'h80,  8'h81,  8'hFF, 1'b1};
    vecs[7] = '{8'hA5,  8'h5A,  8'h4B, 1'b0};

    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    #2;
    chk("reset busy", {31'd0, busy8}, 32'd0);
    chk("reset done", {31'd0, done8}, 32'd0);
    chk("reset diff", {24'd0, diff8}, 32'd0);
    chk("reset borrow", {31'd0, bo8}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      run_op(8, int'(vecs[i].a), int'(vecs[i].b), $sformatf("vec%0d", i),
             vecs[i].exp_diff, vecs[i].exp_bo);
    end

    // Result holds while idle.
    hold = diff8;
    repeat (5) @(negedge clk);
    chk("hold diff", {24'd0, diff8}, {24'd0, hold});

    // Random operations against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 255));
      run_op(8, x, y, $sformatf("rnd%0d", i), 8'(ref_diff(8, x, y)), x < y);
    end

    // Start pulsed again mid-run is ignored.
    d0 = dcnt8;
    start8 = 1'b1; a8 = 8'd9; b8 = 8'd4;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk); start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
    @(negedge clk); start8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("ignore_start diff", {24'd0, diff8}, 32'h05);
    chk("ignore_start borrow", {31'd0, bo8}, 32'd0);
    chk("ignore_start done_count", 32'(dcnt8 - d0), 32'd1);
    chk("ignore_start idle", {31'd0, busy8}, 32'd0);

    // Reset in the middle of a run aborts it immediately.
    d0 = dcnt8;
    start8 = 1'b1; a8 = 8'd20; b8 = 8'd7;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort busy", {31'd0, busy8}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy8}, 32'd0);
    chk("abort diff", {24'd0, diff8}, 32'd0);
    chk("abort borrow", {31'd0, bo8}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort no_done", 32'(dcnt8 - d0), 32'd0);
    run_op(8, 20, 7, "after_abort", 8'h0D, 1'b0);

    // Exhaustive 4-bit sweep, each start at the first edge it can be taken.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(4, i, j, $sformatf("w4_%0d_%0d", i, j), 8'(ref_diff(4, i, j)), i < j);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
